// File: rtl/bullet_scheduler_pkg.sv
// rtl/bullet_scheduler_pkg.sv - shared state encodings and default geometry for the bullet scheduler
package bullet_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_HOLD = 2'd2
    } fire_state_e;

    localparam int DEF_TOP_Y = 66;
    localparam int DEF_SPEED = 4;
    localparam int DEF_POS_W = 10;
    localparam int IDX_W     = 3;

endpackage

// File: rtl/bullet_scheduler_if.sv
// rtl/bullet_scheduler_if.sv - input/sprite bundle between game logic and the bullet scheduler
interface bullet_scheduler_if #(
    parameter int NUM_SLOTS = 4,
    parameter int POS_W     = 10
);
    logic                                     frame_tick;
    logic                                     pbG;
    logic [POS_W-1:0]                         ship_x;
    logic [POS_W-1:0]                         ship_y;
    logic                                     kill_valid;
    logic [bullet_scheduler_pkg::IDX_W-1:0]   kill_slot;
    logic [NUM_SLOTS-1:0]                     slot_active;
    logic [NUM_SLOTS*POS_W-1:0]               slot_x;
    logic [NUM_SLOTS*POS_W-1:0]               slot_y;
    logic                                     fire_accepted;
    logic                                     pool_full;

    modport master (
        output frame_tick, pbG, ship_x, ship_y, kill_valid, kill_slot,
        input  slot_active, slot_x, slot_y, fire_accepted, pool_full
    );

    modport slave (
        input  frame_tick, pbG, ship_x, ship_y, kill_valid, kill_slot,
        output slot_active, slot_x, slot_y, fire_accepted, pool_full
    );
endinterface

// File: rtl/bullet_scheduler_fire_button_sync.sv
// rtl/bullet_scheduler_fire_button_sync.sv - two-flop synchronizer for the active-low fire button
module fire_button_sync (
    input  logic clk,
    input  logic reset,
    input  logic pb_n,
    output logic pressed,
    output logic released
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = pb_n;
        sync2_d = sync1_q;
    end

    // Flops reset to 1 so the button reads as released out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign pressed  = ~sync2_q;
    assign released = sync2_q;
endmodule

// File: rtl/bullet_scheduler.sv
// rtl/bullet_scheduler.sv - bullet slot pool with cooldown and fire FSM; AUTOFIRE_EN repeats shots while held
module bullet_scheduler
    import bullet_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int TOP_Y           = DEF_TOP_Y,
    parameter int SPEED           = DEF_SPEED,
    parameter int POS_W           = DEF_POS_W
) (
    input  logic              clk,
    input  logic              reset,
    bullet_scheduler_if.slave bus
);
    localparam int              CD_W      = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [POS_W-1:0] RETIRE_Y  = POS_W'(TOP_Y + SPEED);
    localparam logic [POS_W-1:0] STEP      = POS_W'(SPEED);
    localparam logic [CD_W-1:0]  CD_RELOAD = CD_W'(COOLDOWN_FRAMES - 1);

    logic btn_pressed, btn_released;

    fire_button_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .pb_n     (bus.pbG),
        .pressed  (btn_pressed),
        .released (btn_released)
    );

    fire_state_e                      state_q, state_d;
    logic [NUM_SLOTS-1:0]             active_q, active_d;
    logic [NUM_SLOTS-1:0][POS_W-1:0]  x_q, x_d;
    logic [NUM_SLOTS-1:0][POS_W-1:0]  y_q, y_d;
    logic [CD_W-1:0]                  cooldown_q, cooldown_d;
    logic                             fire_q, fire_d;
    logic                             full_q, full_d;

    logic [NUM_SLOTS-1:0] kill_mask, free_mask, alloc_sel;
    logic                 accept;

    always_comb begin
        active_d   = active_q;
        x_d        = x_q;
        y_d        = y_q;
        cooldown_d = cooldown_q;
        state_d    = state_q;
        fire_d     = 1'b0;
        accept     = 1'b0;

        for (int i = 0; i < NUM_SLOTS; i++) begin
            kill_mask[i] = bus.kill_valid && (bus.kill_slot == IDX_W'(i));
        end

        // Killed slots stay off-limits to this tick's allocation even if already idle.
        free_mask = ~active_q & ~kill_mask;
        alloc_sel = free_mask & (-free_mask);

        if (bus.frame_tick) begin
            accept = (state_q == S_PEND) && (cooldown_q == '0) && (|free_mask);
            if (cooldown_q != '0) begin
                cooldown_d = cooldown_q - CD_W'(1);
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (active_q[i] && !kill_mask[i]) begin
                    if (y_q[i] <= RETIRE_Y) begin
                        active_d[i] = 1'b0;
                    end else begin
                        y_d[i] = y_q[i] - STEP;
                    end
                end
                if (accept && alloc_sel[i]) begin
                    active_d[i] = 1'b1;
                    x_d[i]      = bus.ship_x;
                    y_d[i]      = bus.ship_y;
                end
            end
            if (accept) begin
                cooldown_d = CD_RELOAD;
                fire_d     = 1'b1;
            end
        end

        active_d = active_d & ~kill_mask;
        full_d   = &active_d;

        unique case (state_q)
            S_IDLE: if (btn_pressed) state_d = S_PEND;
            S_PEND: if (accept) state_d = S_HOLD;
            S_HOLD: begin
`ifdef AUTOFIRE_EN
                if (btn_pressed) state_d = S_PEND;
                else if (btn_released) state_d = S_IDLE;
`else
                if (btn_released) state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            active_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            cooldown_q <= '0;
            fire_q     <= 1'b0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cooldown_q <= cooldown_d;
            fire_q     <= fire_d;
            full_q     <= full_d;
        end
    end

    assign bus.slot_active   = active_q;
    assign bus.slot_x        = x_q;
    assign bus.slot_y        = y_q;
    assign bus.fire_accepted = fire_q;
    assign bus.pool_full     = full_q;
endmodule
